// File: rtl/cpu_dispatcher_pkg.sv
// Shared definitions for the multi-CPU dispatcher and the CPU bridges.
package disp_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ENUM,
    ST_IDLE,
    ST_WAIT,
    ST_RELEASE
  } state_e;

  localparam int TIMER_W = 16;
  localparam int CNT_W   = 16;

  // Index values the bridges compare against to know whether they own the bus.
  localparam logic [31:0] CPU_NONACTIVE = 32'hFFFF_FFFF;
  localparam logic [31:0] CPU_ACTIVE    = 32'h0000_0000;

  function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cpu_dispatcher_if.sv
// Dispatcher <-> bridge handshake bundle; master is the dispatcher side.
interface cpu_dispatcher_if #(
  parameter int NCPU = 4
);
  logic [NCPU-1:0] disp_q;
  logic            next_cpu_e;
  logic            bus_busy;
  logic            ext_rst_b;
  logic            enum_v;
  logic            next_cpu_q;
  logic [31:0]     cpu_index;
  logic [NCPU-1:0] grant;
  logic            timeout_err;
  logic            busy;

  modport master (
    input  disp_q, next_cpu_e, bus_busy,
    output ext_rst_b, enum_v, next_cpu_q, cpu_index, grant, timeout_err, busy
  );

  modport slave (
    output disp_q, next_cpu_e, bus_busy,
    input  ext_rst_b, enum_v, next_cpu_q, cpu_index, grant, timeout_err, busy
  );
endinterface

// File: rtl/cpu_dispatcher_rr_pick.sv
// Combinational round-robin picker: first set request strictly after `last`, wrapping.
module rr_pick #(
  parameter int NCPU = 4
) (
  input  logic [NCPU-1:0]         req,
  input  logic [$clog2(NCPU)-1:0] last,
  output logic [$clog2(NCPU)-1:0] idx,
  output logic                    valid
);
  localparam int IW = $clog2(NCPU);

  logic [2*NCPU-1:0] dbl;
  logic [NCPU-1:0]   rot;
  logic [IW:0]       sh;
  logic [IW:0]       k_sel;
  logic [IW:0]       sum;

  // Doubling the vector turns the wrap-around rotation into a plain shift.
  assign dbl = {req, req};
  assign sh  = {1'b0, last} + (IW+1)'(1);
  assign rot = NCPU'(dbl >> sh);

  always_comb begin
    k_sel = '0;
    valid = 1'b0;
    for (int k = NCPU-1; k >= 0; k--) begin
      if (rot[k]) begin
        k_sel = (IW+1)'(k);
        valid = 1'b1;
      end
    end
  end

  assign sum = sh + k_sel;
  assign idx = (sum >= (IW+1)'(NCPU)) ? IW'(sum - (IW+1)'(NCPU)) : IW'(sum);

endmodule

// File: rtl/cpu_dispatcher.sv
// Bridge reset/enumeration sequencer and round-robin bus granter with grant timeout.
module cpu_dispatcher
  import disp_pkg::*;
#(
  parameter int NCPU    = 4,
  parameter int RST_CYC = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  cpu_dispatcher_if.master   bus
);
  localparam int IW = $clog2(NCPU);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [TIMER_W-1:0]   timer_inc;
  logic [IW-1:0]        last_q, last_d;
  logic [IW-1:0]        cur_q, cur_d;
  logic [31:0]          cpu_index_q, cpu_index_d;
  logic [NCPU-1:0]      grant_q, grant_d;
  logic                 nxt_q, nxt_d;
  logic                 ext_rst_b_q, ext_rst_b_d;
  logic                 enum_v_q, enum_v_d;
  logic                 tmo_q, tmo_d;
  logic                 busy_q, busy_d;

  logic [IW-1:0]        pick_idx;
  logic                 pick_valid;

  rr_pick #(.NCPU(NCPU)) u_pick (
    .req   (bus.disp_q),
    .last  (last_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign timer_inc = sat_inc(timer_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    last_d      = last_q;
    cur_d       = cur_q;
    cpu_index_d = cpu_index_q;
    grant_d     = grant_q;
    nxt_d       = nxt_q;
    ext_rst_b_d = 1'b0;
    enum_v_d    = 1'b0;
    tmo_d       = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        ext_rst_b_d = 1'b1;
        if (cnt_q >= CNT_W'(RST_CYC-1)) begin
          cnt_d   = '0;
          state_d = ST_ENUM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ENUM: begin
        enum_v_d    = 1'b1;
        cpu_index_d = 32'(cnt_q);
        if (cnt_q >= CNT_W'(NCPU-1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (!bus.bus_busy && pick_valid) begin
          cur_d       = pick_idx;
          cpu_index_d = 32'(pick_idx);
          grant_d     = NCPU'(1) << pick_idx;
          nxt_d       = 1'b1;
          timer_d     = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_inc;
        // Completion wins over a timeout landing on the same edge.
        if (bus.next_cpu_e) begin
          last_d  = cur_q;
          nxt_d   = 1'b0;
          grant_d = '0;
          state_d = ST_RELEASE;
        end else if (timer_inc >= TIMER_W'(TIMEOUT)) begin
          tmo_d   = 1'b1;
          last_d  = cur_q;
          nxt_d   = 1'b0;
          grant_d = '0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      timer_q     <= '0;
      last_q      <= IW'(NCPU-1);
      cur_q       <= '0;
      cpu_index_q <= '0;
      grant_q     <= '0;
      nxt_q       <= 1'b0;
      ext_rst_b_q <= 1'b0;
      enum_v_q    <= 1'b0;
      tmo_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      last_q      <= last_d;
      cur_q       <= cur_d;
      cpu_index_q <= cpu_index_d;
      grant_q     <= grant_d;
      nxt_q       <= nxt_d;
      ext_rst_b_q <= ext_rst_b_d;
      enum_v_q    <= enum_v_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ext_rst_b   = ext_rst_b_q;
  assign bus.enum_v      = enum_v_q;
  assign bus.next_cpu_q  = nxt_q;
  assign bus.cpu_index   = cpu_index_q;
  assign bus.grant       = grant_q;
  assign bus.timeout_err = tmo_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_cpu_dispatcher.sv
// Self-checking bench: reset/enum vector table, grant scoreboard, timeout and reset corner cases.
module tb_cpu_dispatcher;
  localparam int NCPU    = 4;
  localparam int RST_CYC = 4;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_dispatcher_if #(.NCPU(NCPU)) dif ();

  cpu_dispatcher #(.NCPU(NCPU), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.master)
  );

  typedef struct {
    logic [NCPU-1:0] disp;
    logic            ext_rst_b;
    logic            enum_v;
    logic [31:0]     idx;
    logic            busy;
  } rvec_t;

  rvec_t tbl [9];

  int pass_cnt = 0;
  int total_cnt = 0;
  int tmo_cnt = 0;
  int exp_q [$];
  logic prev_nxt = 1'b0;
  logic resp_en = 1'b0;
  int resp_delay = 3;
  int hi_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (dif.next_cpu_q) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!dif.busy && !dif.next_cpu_q) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  // Expects rst to have just been released #1 after a clock edge.
  task automatic run_reset_seq(input string tag);
    dif.disp_q = '1;
    for (int k = 0; k < 9; k++) begin
      step();
      chk({tag, "_ext_rst_b"}, 32'(dif.ext_rst_b), 32'(tbl[k].ext_rst_b));
      chk({tag, "_enum_v"},    32'(dif.enum_v),    32'(tbl[k].enum_v));
      chk({tag, "_cpu_index"}, dif.cpu_index,      tbl[k].idx);
      chk({tag, "_busy"},      32'(dif.busy),      32'(tbl[k].busy));
      chk({tag, "_no_grant"},  32'(dif.next_cpu_q), 32'd0);
      $display("reset seq %s cycle %0d: ext_rst_b=%0b enum_v=%0b cpu_index=%0d busy=%0b",
               tag, k+1, dif.ext_rst_b, dif.enum_v, dif.cpu_index, dif.busy);
      dif.disp_q = tbl[k].disp;
    end
  endtask

  // Scoreboard: every rising next_cpu_q consumes one expected CPU index.
  initial begin
    forever begin
      step();
      if (dif.timeout_err) tmo_cnt++;
      if (dif.next_cpu_q && !prev_nxt) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_grant: cpu_index %0d granted, none expected", dif.cpu_index);
        end else begin
          int e;
          e = exp_q.pop_front();
          chk("grant_idx", dif.cpu_index, 32'(e));
          chk("grant_onehot", 32'(dif.grant), 32'(1) << e);
          $display("grant: cpu_index=%0d grant=%b expected cpu %0d", dif.cpu_index, dif.grant, e);
        end
      end
      prev_nxt = dif.next_cpu_q;
    end
  end

  // Bridge model: finishes its bus phase once next_cpu_q has been seen resp_delay times.
  initial begin
    dif.next_cpu_e = 1'b0;
    forever begin
      step();
      if (dif.next_cpu_q) hi_cnt++;
      else hi_cnt = 0;
      dif.next_cpu_e = resp_en && dif.next_cpu_q && (hi_cnt >= resp_delay);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) tbl[k] = '{4'b1111, 1'b1, 1'b0, 32'd0, 1'b1};
    tbl[4] = '{4'b1111, 1'b0, 1'b1, 32'd0, 1'b1};
    tbl[5] = '{4'b1111, 1'b0, 1'b1, 32'd1, 1'b1};
    tbl[6] = '{4'b1111, 1'b0, 1'b1, 32'd2, 1'b1};
    tbl[7] = '{4'b0000, 1'b0, 1'b1, 32'd3, 1'b0};
    tbl[8] = '{4'b0000, 1'b0, 1'b0, 32'd3, 1'b0};

    dif.disp_q   = '0;
    dif.bus_busy = 1'b0;
    #1 rst = 1'b1;
    repeat (2) step();
    chk("rst_next_cpu_q", 32'(dif.next_cpu_q), 32'd0);
    chk("rst_cpu_index",  dif.cpu_index,       32'd0);
    chk("rst_grant",      32'(dif.grant),      32'd0);
    chk("rst_ext_rst_b",  32'(dif.ext_rst_b),  32'd0);
    chk("rst_enum_v",     32'(dif.enum_v),     32'd0);
    chk("rst_busy",       32'(dif.busy),       32'd0);
    chk("rst_timeout",    32'(dif.timeout_err), 32'd0);
    rst = 1'b0;
    run_reset_seq("init");

    // Round-robin with all CPUs requesting, each grant 3 cycles long.
    resp_en = 1'b1;
    resp_delay = 3;
    exp_q = '{0, 1, 2, 3, 0};
    dif.disp_q = 4'b1111;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    chk("rr_all_granted", 32'(exp_q.size()), 32'd0);
    dif.disp_q = '0;
    wait_idle("rr_idle");

    // bus_busy blocks any new grant.
    dif.bus_busy = 1'b1;
    dif.disp_q = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("busbusy_no_grant", 32'(dif.next_cpu_q), 32'd0);
    end
    dif.bus_busy = 1'b0;
    exp_q.push_back(2);
    step();
    chk("busbusy_release_grant", 32'(dif.next_cpu_q), 32'd1);
    chk("busbusy_release_idx", dif.cpu_index, 32'd2);
    $display("bus_busy release: next_cpu_q=%0b cpu_index=%0d", dif.next_cpu_q, dif.cpu_index);
    dif.disp_q = '0;
    wait_idle("busbusy_idle");

    // Timeout on CPU1, then the next requester after 1 (CPU3) wins.
    resp_en = 1'b0;
    dif.disp_q = 4'b0010;
    exp_q.push_back(1);
    wait_grant("tmo_grant");
    dif.disp_q = 4'b1011;
    exp_q.push_back(3);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("tmo_err_early", 32'(dif.timeout_err), 32'd0);
      chk("tmo_hold", 32'(dif.next_cpu_q), 32'd1);
    end
    step();
    chk("tmo_err_pulse", 32'(dif.timeout_err), 32'd1);
    chk("tmo_release", 32'(dif.next_cpu_q), 32'd0);
    chk("tmo_grant_clear", 32'(dif.grant), 32'd0);
    chk("tmo_index_kept", dif.cpu_index, 32'd1);
    $display("timeout: timeout_err=%0b next_cpu_q=%0b", dif.timeout_err, dif.next_cpu_q);
    step();
    chk("tmo_err_single", 32'(dif.timeout_err), 32'd0);
    step();
    chk("tmo_next_grant", 32'(dif.next_cpu_q), 32'd1);
    chk("tmo_next_idx", dif.cpu_index, 32'd3);
    dif.disp_q = '0;
    resp_en = 1'b1;
    resp_delay = 3;
    wait_idle("tmo_idle");
    chk("tmo_count", 32'(tmo_cnt), 32'd1);

    // Completion on exactly the timeout edge; request dropped mid-grant.
    resp_delay = TIMEOUT;
    dif.disp_q = 4'b0001;
    exp_q.push_back(0);
    wait_grant("sim_grant");
    dif.disp_q = '0;
    repeat (4) step();
    chk("drop_ignored", 32'(dif.next_cpu_q), 32'd1);
    repeat (4) step();
    chk("sim_release", 32'(dif.next_cpu_q), 32'd0);
    chk("sim_no_err", 32'(dif.timeout_err), 32'd0);
    step();
    chk("sim_no_err_late", 32'(dif.timeout_err), 32'd0);
    chk("sim_idle", 32'(dif.busy), 32'd0);
    chk("sim_tmo_count", 32'(tmo_cnt), 32'd1);
    $display("simultaneous completion: timeout count %0d", tmo_cnt);
    resp_delay = 3;

    // Asynchronous reset in the middle of a grant.
    resp_en = 1'b0;
    dif.disp_q = 4'b0100;
    exp_q.push_back(2);
    wait_grant("mid_grant");
    dif.disp_q = '0;
    repeat (2) step();
    #2 rst = 1'b1;
    #1;
    chk("midrst_next_cpu_q", 32'(dif.next_cpu_q), 32'd0);
    chk("midrst_grant", 32'(dif.grant), 32'd0);
    chk("midrst_cpu_index", dif.cpu_index, 32'd0);
    chk("midrst_busy", 32'(dif.busy), 32'd0);
    $display("reset mid-grant: next_cpu_q=%0b grant=%b cpu_index=%0d",
             dif.next_cpu_q, dif.grant, dif.cpu_index);
    step();
    rst = 1'b0;
    run_reset_seq("reinit");

    // Pointer is back at NCPU-1, so CPU0 wins first.
    resp_en = 1'b1;
    exp_q.push_back(0);
    dif.disp_q = 4'b1111;
    wait_grant("post_rst_grant");
    dif.disp_q = '0;
    wait_idle("post_rst_idle");
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
